// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider:
//   - div_state_e : FSM state encoding (IDLE, RUN, FIX, DZ, DONE)
//   - twos_neg    : two's-complement negate on a wide vector; callers
//                   zero-extend into DIV_MAX_W bits and truncate the result
//                   back to their own width (negation mod 2**N is preserved).
// ----------------------------------------------------------------------------
package div_pkg;

    localparam int unsigned DIV_MAX_W = 64;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_FIX  = 3'd2,
        S_DZ   = 3'd3,
        S_DONE = 3'd4
    } div_state_e;

    function automatic logic [DIV_MAX_W-1:0] twos_neg(input logic [DIV_MAX_W-1:0] v);
        return ~v + DIV_MAX_W'(1);
    endfunction

endpackage

// File: rtl/div_seq_param_step.sv
// ----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step on magnitudes.
//   a_i : partial remainder (always < m_i)
//   q_i : dividend bits still to shift in / quotient bits produced so far
//   m_i : divisor magnitude
//   a_o : next partial remainder
//   q_o : next quotient/dividend register
// {A,Q} is shifted left by one; the trial subtraction is done one bit wider
// than the shifted remainder so a borrow is visible as the top bit.
// ----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0]   a_sh;
    logic [WIDTH+1:0] diff;

    always_comb begin
        a_sh = {a_i, q_i[WIDTH-1]};
        diff = {1'b0, a_sh} - {2'b00, m_i};
        if (!diff[WIDTH+1]) begin
            // result is < m_i, so it always fits in WIDTH bits
            a_o = WIDTH'(diff);
            q_o = {q_i[WIDTH-2:0], 1'b1};
        end else begin
            a_o = a_sh[WIDTH-1:0];
            q_o = {q_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq_param.sv
// ----------------------------------------------------------------------------
// div_seq_param
// Multi-cycle restoring integer divider, signed or unsigned per operation.
// Ports:
//   clk            : rising-edge clock
//   clr            : synchronous reset, active-low
//   start          : request, accepted only in IDLE or DONE
//   is_signed      : 1 = two's-complement operands
//   dividend/divisor : operands, sampled with an accepted start
//   busy           : operation in progress (RUN or FIX)
//   ready          : results valid, held until the next accepted start
//   quotient       : truncated toward zero
//   remainder      : sign follows dividend
//   data_exception : divisor was zero
//   overflow       : signed MIN / -1
// Latency: WIDTH+1 cycles, or 1 cycle for a zero divisor.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// RUN    | WIDTH restoring steps on magnitudes
// FIX    | apply signs, publish results
// DZ     | zero divisor, publish exception result
// DONE   | results held, waiting for start
// ----------------------------------------------------------------------------
module div_seq_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             data_exception,
    output logic             overflow
);
    import div_pkg::*;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH-1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return WIDTH'(twos_neg(DIV_MAX_W'(v)));
    endfunction

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, q_q, q_d, m_q, m_d;
    logic             sd_q, sd_d, sv_q, sv_d, ovfp_q, ovfp_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic             ready_q, ready_d, dexc_q, dexc_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] step_a, step_q;
    logic             accept, in_neg, dv_neg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .a_i (a_q),
        .q_i (q_q),
        .m_i (m_q),
        .a_o (step_a),
        .q_o (step_q)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            sd_q    <= 1'b0;
            sv_q    <= 1'b0;
            ovfp_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            ready_q <= 1'b0;
            dexc_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            sd_q    <= sd_d;
            sv_q    <= sv_d;
            ovfp_q  <= ovfp_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ready_q <= ready_d;
            dexc_q  <= dexc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        sd_d    = sd_q;
        sv_d    = sv_q;
        ovfp_d  = ovfp_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ready_d = ready_q;
        dexc_d  = dexc_q;
        ovf_d   = ovf_q;
        accept  = 1'b0;
        in_neg  = is_signed & dividend[WIDTH-1];
        dv_neg  = is_signed & divisor[WIDTH-1];

        case (state_q)
            S_IDLE, S_DONE: accept = start;
            S_RUN: begin
                a_d   = step_a;
                q_d   = step_q;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) state_d = S_FIX;
            end
            S_FIX: begin
                // MIN/-1 needs no special case: |MIN| / 1 leaves Q = MIN, A = 0
                quot_d  = (sd_q ^ sv_q) ? neg_w(q_q) : q_q;
                rem_d   = sd_q ? neg_w(a_q) : a_q;
                ovf_d   = ovfp_q;
                ready_d = 1'b1;
                state_d = S_DONE;
            end
            S_DZ: begin
                // Q holds the raw dividend on this path
                quot_d  = '0;
                rem_d   = q_q;
                dexc_d  = 1'b1;
                ready_d = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            sd_d    = in_neg;
            sv_d    = dv_neg;
            m_d     = dv_neg ? neg_w(divisor) : divisor;
            a_d     = '0;
            cnt_d   = '0;
            ready_d = 1'b0;
            dexc_d  = 1'b0;
            ovf_d   = 1'b0;
            ovfp_d  = is_signed & (dividend == MIN_VAL) & (divisor == '1);
            if (divisor == '0) begin
                q_d     = dividend;
                state_d = S_DZ;
            end else begin
                q_d     = in_neg ? neg_w(dividend) : dividend;
                state_d = S_RUN;
            end
        end
    end

    assign busy           = (state_q == S_RUN) || (state_q == S_FIX);
    assign ready          = ready_q;
    assign quotient       = quot_q;
    assign remainder      = rem_q;
    assign data_exception = dexc_q;
    assign overflow       = ovf_q;

endmodule

// File: tb/tb_div_seq_param.sv
module tb_div_seq_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr;
    logic        st32, sg32, busy32, rdy32, dz32, ov32;
    logic [31:0] dd32, dv32, q32, r32;
    logic        st8, sg8, busy8, rdy8, dz8, ov8;
    logic [7:0]  dd8, dv8, q8, r8;

    div_seq_param #(.WIDTH(32), .CNT_W(6)) dut32 (
        .clk(clk), .clr(clr), .start(st32), .is_signed(sg32),
        .dividend(dd32), .divisor(dv32), .busy(busy32), .ready(rdy32),
        .quotient(q32), .remainder(r32), .data_exception(dz32), .overflow(ov32)
    );

    div_seq_param #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .clr(clr), .start(st8), .is_signed(sg8),
        .dividend(dd8), .divisor(dv8), .busy(busy8), .ready(rdy8),
        .quotient(q8), .remainder(r8), .data_exception(dz8), .overflow(ov8)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit          w8;
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        bit          dz;
        bit          ov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on mathematical values.
    function automatic void model(input int w, input bit sgn, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] q,
                                  output logic [31:0] r, output bit dz, output bit ov);
        longint sa, sb, mn;
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 32'd0) begin
            dz = 1'b1; q = 32'd0; r = a;
        end else if (!sgn) begin
            q = a / b; r = a % b;
        end else begin
            mn = -(longint'(1) <<< (w - 1));
            sa = a[w-1] ? longint'({32'd0, a}) - (longint'(1) <<< w) : longint'({32'd0, a});
            sb = b[w-1] ? longint'({32'd0, b}) - (longint'(1) <<< w) : longint'({32'd0, b});
            if (sa == mn && sb == -1) begin
                ov = 1'b1; q = 32'(mn) & mask; r = 32'd0;
            end else begin
                q = 32'(sa / sb) & mask;
                r = 32'(sa % sb) & mask;
            end
        end
    endfunction

    task automatic drive(input bit w8, input logic st, input logic sg,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            st8 = st; sg8 = sg; dd8 = a[7:0]; dv8 = b[7:0];
        end else begin
            st32 = st; sg32 = sg; dd32 = a; dv32 = b;
        end
    endtask

    task automatic sample(input bit w8, output logic [31:0] q, output logic [31:0] r,
                          output logic rd, output logic bs, output logic dz, output logic ov);
        if (w8) begin
            q = {24'd0, q8}; r = {24'd0, r8}; rd = rdy8; bs = busy8; dz = dz8; ov = ov8;
        end else begin
            q = q32; r = r32; rd = rdy32; bs = busy32; dz = dz32; ov = ov32;
        end
    endtask

    // Runs one operation; inject_at > 0 pulses a competing start on that edge after accept.
    task automatic do_op(input bit w8, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input bit edz,
                         input bit eov, input int inject_at, input string tag);
        logic [31:0] sq, sr, prev_q;
        logic        srd, sbs, sdz, sov;
        int          lat, exp_lat;
        bit          got;
        exp_lat = edz ? 1 : (w8 ? 9 : 33);
        @(negedge clk);
        sample(w8, prev_q, sr, srd, sbs, sdz, sov);
        drive(w8, 1'b1, sgn, a, b);
        @(posedge clk);
        #1;
        drive(w8, 1'b0, sgn, a, b);
        sample(w8, sq, sr, srd, sbs, sdz, sov);
        chk({tag, " ready_low_at_accept"}, {31'd0, srd}, 32'd0);
        chk({tag, " busy_at_accept"}, {31'd0, sbs}, {31'd0, !edz});
        chk({tag, " q_held_at_accept"}, sq, prev_q);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            if (lat + 1 == inject_at) drive(w8, 1'b1, 1'b0, 32'd7, 32'd7);
            else drive(w8, 1'b0, sgn, a, b);
            @(posedge clk);
            #1;
            lat++;
            sample(w8, sq, sr, srd, sbs, sdz, sov);
            got = srd;
        end
        drive(w8, 1'b0, sgn, a, b);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " quotient"}, sq, eq);
        chk({tag, " remainder"}, sr, er);
        chk({tag, " flags"}, {30'd0, sdz, sov}, {30'd0, edz, eov});
        chk({tag, " busy_done"}, {31'd0, sbs}, 32'd0);
    endtask

    task automatic check_zero32(input string tag);
        chk({tag, " busy"}, {31'd0, busy32}, 32'd0);
        chk({tag, " ready"}, {31'd0, rdy32}, 32'd0);
        chk({tag, " quotient"}, q32, 32'd0);
        chk({tag, " remainder"}, r32, 32'd0);
        chk({tag, " flags"}, {30'd0, dz32, ov32}, 32'd0);
    endtask

    initial begin
        vec_t        tbl[$];
        logic [31:0] ra, rb, eq, er;
        bit          edz, eov, w8, sgn;

        tbl = '{
            '{0, 0, 32'd100,        32'd7,        32'd14,       32'd2,        0, 0},
            '{0, 1, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, 0},
            '{0, 1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,       0, 0},
            '{0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       0, 1},
            '{0, 0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 0, 0},
            '{0, 0, 32'd1234,       32'd0,        32'd0,        32'd1234,     1, 0},
            '{0, 0, 32'd9,          32'd3,        32'd3,        32'd0,        0, 0},
            '{0, 1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,       32'hFFFF_FFFF, 0, 0},
            '{0, 0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,       0, 0},
            '{1, 1, 32'h80,         32'h03,       32'hD6,       32'hFE,       0, 0},
            '{1, 0, 32'hFF,         32'h10,       32'h0F,       32'h0F,       0, 0},
            '{1, 1, 32'h80,         32'hFF,       32'h80,       32'h00,       0, 1},
            '{1, 0, 32'h05,         32'h00,       32'h00,       32'h05,       1, 0}
        };

        clr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_zero32("reset32");
        chk("reset8 outputs", {q8, r8, rdy8, busy8, dz8, ov8, 12'd0}, 32'd0);
        @(negedge clk);
        clr = 1'b1;

        foreach (tbl[i])
            do_op(tbl[i].w8, tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
                  tbl[i].dz, tbl[i].ov, 0, $sformatf("vec%0d", i));

        // competing start during RUN must be ignored
        do_op(1'b0, 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0, 5, "ignore_start");

        // reset at cycle 10 of RUN discards everything
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        check_zero32("midrun_reset");
        @(negedge clk);
        clr = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_after_reset ready/busy", {30'd0, rdy32, busy32}, 32'd0);
        do_op(1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 0, "post_reset");

        // start together with reset: reset wins
        @(negedge clk);
        clr = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'd50, 32'd5);
        @(posedge clk);
        #1;
        check_zero32("start_with_reset");
        @(negedge clk);
        clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd50, 32'd5);

        for (int i = 0; i < 50; i++) begin
            w8  = $urandom_range(0, 1);
            sgn = $urandom_range(0, 1);
            case ($urandom_range(0, 4))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                2: ra = $urandom_range(0, 20);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 9);
                default: rb = $urandom;
            endcase
            if (w8) begin
                ra = (ra == 32'h8000_0000) ? 32'h80 : (ra & 32'hFF);
                rb = rb & 32'hFF;
            end
            model(w8 ? 8 : 32, sgn, ra, rb, eq, er, edz, eov);
            do_op(w8, sgn, ra, rb, eq, er, edz, eov, 0, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
